// File: rtl/ripple_down_timer_pkg.sv
// ---------------------------------------------------------------------------
// ripple_timer_pkg
//   Shared constants for the ripple_down_timer slice: FSM state encoding,
//   default parameter values and a helper that sizes the prescaler counter.
//   Optional feature macro used elsewhere in the slice: AUTO_RELOAD_EN.
// ---------------------------------------------------------------------------
package ripple_timer_pkg;

  // FSM state encoding, kept as plain constants for legacy tools.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Default build parameters.
  localparam int DEF_WIDTH    = 2;
  localparam int DEF_PRESCALE = 1;

  // Prescaler counter width: enough bits to hold PRESCALE-1, never below 1
  // so a PRESCALE of 1 still yields a legal vector.
  function automatic int presc_width(input int prescale);
    return (prescale > 1) ? $clog2(prescale) : 1;
  endfunction

endpackage : ripple_timer_pkg

// File: rtl/ripple_down_timer_if.sv
// ---------------------------------------------------------------------------
// ripple_down_timer_if
//   Control/status bundle of the down timer.
//   master : drives start, load_val, pause; observes out, busy, done.
//   slave  : the timer itself; the opposite directions.
//   Signals:
//     start    1      one-cycle load-and-run request (level sampled)
//     load_val WIDTH  start value
//     pause    1      freeze count and prescaler while high
//     out      WIDTH  current count
//     busy     1      timer is running
//     done     1      one-cycle expiry pulse
// ---------------------------------------------------------------------------
interface ripple_down_timer_if #(
  parameter int WIDTH = ripple_timer_pkg::DEF_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] load_val;
  logic             pause;
  logic [WIDTH-1:0] out;
  logic             busy;
  logic             done;

  modport master (
    output start, load_val, pause,
    input  out, busy, done
  );

  modport slave (
    input  start, load_val, pause,
    output out, busy, done
  );
endinterface : ripple_down_timer_if

// File: rtl/ripple_down_timer_tick_gen.sv
// ---------------------------------------------------------------------------
// tick_gen
//   Prescaler for the down timer. Counts 0..PRESCALE-1 while not held and
//   raises tick on the last count; the counter wraps to 0 on that same edge.
//   With PRESCALE=1 the counter stays at 0 and tick follows ~hold.
//   Ports:
//     clk   in   system clock
//     rst   in   synchronous active-high reset
//     clr   in   clear the prescaler (wins over hold)
//     hold  in   freeze the prescaler and suppress tick
//     tick  out  decrement strobe for the owning timer
// ---------------------------------------------------------------------------
module tick_gen
  import ripple_timer_pkg::*;
#(
  parameter int PRESCALE = DEF_PRESCALE
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic hold,
  output logic tick
);

  localparam int            CW   = presc_width(PRESCALE);
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (!hold) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign tick = !hold && (cnt == LAST);

endmodule : tick_gen

// File: rtl/ripple_down_timer.sv
// ---------------------------------------------------------------------------
// ripple_down_timer
//   Loadable down-counting timer. A start loads load_val and counts it down
//   by one per prescaled tick; reaching zero drops busy and pulses done for
//   one cycle. A start with load_val=0 pulses done without running. A start
//   while running restarts the count and clears the prescaler.
//   Optional feature (macro AUTO_RELOAD_EN): on expiry with a non-zero
//   load_val the count reloads and keeps running, pulsing done each period.
//   Ports:
//     clk  in     system clock, rising edge
//     rst  in     synchronous active-high reset
//     bus  slave  ripple_down_timer_if (start, load_val, pause / out, busy, done)
// ---------------------------------------------------------------------------
module ripple_down_timer
  import ripple_timer_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int PRESCALE = DEF_PRESCALE
) (
  input  logic                clk,
  input  logic                rst,
  ripple_down_timer_if.slave  bus
);

  logic [0:0]       state;
  logic [WIDTH-1:0] count;
  logic             done_q;
  logic             tick;
  logic             lv_zero;

  assign lv_zero = (bus.load_val == '0);

  // The prescaler only advances while running and unpaused; a start always
  // re-aligns it so the first step after a (re)load takes a full period.
  tick_gen #(
    .PRESCALE (PRESCALE)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .clr  (bus.start),
    .hold (bus.pause || (state == ST_IDLE)),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      count  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.start) begin
        // Start (or restart) beats any coincident tick or pause.
        if (lv_zero) begin
          state  <= ST_IDLE;
          count  <= '0;
          done_q <= 1'b1;
        end else begin
          state <= ST_RUN;
          count <= bus.load_val;
        end
      end else if ((state == ST_RUN) && tick) begin
        if (count > WIDTH'(1)) begin
          count <= count - 1'b1;
        end else begin
          done_q <= 1'b1;
`ifdef AUTO_RELOAD_EN
          if (!lv_zero) begin
            count <= bus.load_val;
          end else begin
            state <= ST_IDLE;
            count <= '0;
          end
`else
          state <= ST_IDLE;
          count <= '0;
`endif
        end
      end
    end
  end

  assign bus.out  = count;
  assign bus.busy = (state == ST_RUN);
  assign bus.done = done_q;

endmodule : ripple_down_timer

// File: tb/tb_ripple_down_timer.sv
// ---------------------------------------------------------------------------
// tb_ripple_down_timer
//   Two timers (PRESCALE=1 and PRESCALE=4, WIDTH=2) share one stimulus.
//   The reference tracks the remaining active cycles until expiry; the count
//   shown is that figure divided by PRESCALE, rounded up.
// ---------------------------------------------------------------------------
module tb_ripple_down_timer;

  localparam int W = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         pause;
  logic [W-1:0] load_val;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ripple_down_timer_if #(.WIDTH(W)) if1 ();
  ripple_down_timer_if #(.WIDTH(W)) if4 ();

  assign if1.start    = start;
  assign if1.pause    = pause;
  assign if1.load_val = load_val;
  assign if4.start    = start;
  assign if4.pause    = pause;
  assign if4.load_val = load_val;

  ripple_down_timer #(.WIDTH(W), .PRESCALE(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (if1.slave)
  );

  ripple_down_timer #(.WIDTH(W), .PRESCALE(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (if4.slave)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int m_rem  [2];
  bit m_run  [2];
  bit m_done [2];
  bit m_valid = 1'b0;

  function automatic int ps(input int i);
    return (i == 0) ? 1 : 4;
  endfunction

  function automatic int m_out(input int i);
    return m_run[i] ? (m_rem[i] + ps(i) - 1) / ps(i) : 0;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_rem[i]  = 0;
        m_run[i]  = 1'b0;
        m_done[i] = 1'b0;
      end else begin
        m_done[i] = 1'b0;
        if (start) begin
          if (load_val != 0) begin
            m_rem[i] = int'(load_val) * ps(i);
            m_run[i] = 1'b1;
          end else begin
            m_rem[i]  = 0;
            m_run[i]  = 1'b0;
            m_done[i] = 1'b1;
          end
        end else if (m_run[i] && !pause) begin
          m_rem[i]--;
          if (m_rem[i] == 0) begin
            m_done[i] = 1'b1;
`ifdef AUTO_RELOAD_EN
            if (load_val != 0) m_rem[i] = int'(load_val) * ps(i);
            else               m_run[i] = 1'b0;
`else
            m_run[i] = 1'b0;
`endif
          end
        end
      end
    end
    if (rst) m_valid = 1'b1;
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (m_valid) begin
      check("p1_out",  int'(if1.out),  m_out(0));
      check("p1_busy", int'(if1.busy), int'(m_run[0]));
      check("p1_done", int'(if1.done), int'(m_done[0]));
      check("p4_out",  int'(if4.out),  m_out(1));
      check("p4_busy", int'(if4.busy), int'(m_run[1]));
      check("p4_done", int'(if4.done), int'(m_done[1]));
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  // ---------------- stimulus + literal pins ----------------
  initial begin
    rst = 1'b1; start = 1'b0; pause = 1'b0; load_val = '0;
    step(); step();
    check("rst_out",  int'(if1.out),  0);
    check("rst_busy", int'(if1.busy), 0);
    check("rst_done", int'(if1.done), 0);
    rst = 1'b0;
    step();

    // 1: PRESCALE=1, load 3 -> 3,2,1,0
    start = 1'b1; load_val = 2'd3; step(); start = 1'b0;
    check("s1_out3",  int'(if1.out), 3);
    check("s1_busy",  int'(if1.busy), 1);
    step(); check("s1_out2", int'(if1.out), 2);
    step(); check("s1_out1", int'(if1.out), 1);
    check("s1_nodone", int'(if1.done), 0);
    step();
    check("s1_out0",  int'(if1.out),  0);
    check("s1_done",  int'(if1.done), 1);
    check("s1_idle",  int'(if1.busy), 0);
    step(); check("s1_done_clr", int'(if1.done), 0);

    // 2: PRESCALE=4, load 2 -> 2 x4, 1 x4, then 0 with done
    start = 1'b1; load_val = 2'd2; step(); start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("s2_out", int'(if4.out), (i < 4) ? 2 : 1);
      check("s2_nodone", int'(if4.done), 0);
      step();
    end
    check("s2_out0", int'(if4.out),  0);
    check("s2_done", int'(if4.done), 1);
    check("s2_busy", int'(if4.busy), 0);
    repeat (4) step();

    // 3: pause five cycles at out=2
    start = 1'b1; load_val = 2'd3; step(); start = 1'b0;
    step(); check("s3_out2", int'(if1.out), 2);
    pause = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("s3_hold", int'(if1.out), 2);
      check("s3_busy", int'(if1.busy), 1);
    end
    pause = 1'b0;
    step(); check("s3_out1", int'(if1.out), 1);
    step(); check("s3_out0", int'(if1.out), 0);
    check("s3_done", int'(if1.done), 1);

    // 4: restart at out=1, then start with load_val=0
    start = 1'b1; load_val = 2'd3; step(); start = 1'b0;
    step(); step(); check("s4_out1", int'(if1.out), 1);
    start = 1'b1; step(); start = 1'b0;
    check("s4_reload", int'(if1.out),  3);
    check("s4_nodone", int'(if1.done), 0);
    step(); step(); step();
    check("s4_out0", int'(if1.out),  0);
    check("s4_done", int'(if1.done), 1);
    start = 1'b1; load_val = 2'd0; step(); start = 1'b0;
    check("s4_zdone", int'(if1.done), 1);
    check("s4_zbusy", int'(if1.busy), 0);
    step(); check("s4_zclr", int'(if1.done), 0);
    repeat (12) step();

    // 5: reset mid-count
    start = 1'b1; load_val = 2'd3; step(); start = 1'b0;
    step(); check("s5_out2", int'(if1.out), 2);
    rst = 1'b1; step(); rst = 1'b0;
    check("s5_out",  int'(if1.out),  0);
    check("s5_busy", int'(if1.busy), 0);
    check("s5_done", int'(if1.done), 0);
    for (int i = 0; i < 6; i++) begin
      step();
      check("s5_quiet", int'(if1.done), 0);
    end

`ifdef AUTO_RELOAD_EN
    // 6: auto reload 2,1,2,1,... then stop with load_val=0
    start = 1'b1; load_val = 2'd2; step(); start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check("s6_out",  int'(if1.out),  (i % 2 == 0) ? 2 : 1);
      check("s6_done", int'(if1.done), (i > 0 && i % 2 == 0) ? 1 : 0);
      if (i < 5) step();
    end
    load_val = 2'd0; step();
    check("s6_out0", int'(if1.out),  0);
    check("s6_busy", int'(if1.busy), 0);
    check("s6_done_last", int'(if1.done), 1);
    repeat (8) step();
`endif

    // Randomised phase
    for (int c = 0; c < 3000; c++) begin
      rst      = ($urandom_range(199) == 0);
      start    = ($urandom_range(11) == 0);
      pause    = ($urandom_range(3) == 0);
      load_val = W'($urandom_range(3));
      step();
    end
    rst = 1'b0; start = 1'b0; pause = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_ripple_down_timer

// File: doc/ripple_down_timer.md
Name: ripple_down_timer

Overview:
- Loadable down-counting timer; the counterpart of the team's free-running 2-bit up ripple counter.
- Counts a programmed value down to zero, one step per prescaled tick.
- Reports `busy`, and flags expiry with a one-cycle `done` pulse.
- Used as the timeout/delay source next to the up counter in small control blocks.

Parameters:
- WIDTH, 2, width of `load_val` and `out`.
- PRESCALE, 1, clock cycles per decrement tick; legal range ≥1. When 1, the tick is constant-high.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  reset; synchronous and active-high; one clock; overrides every other input.
- start  input  1  one-cycle request: load `load_val` and begin counting.
- load_val  input  WIDTH  start value, sampled only on an accepted start or reload.
- pause  input  1  level; while high, `out` and the prescaler hold.
- out  output  WIDTH  current count, registered.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse on the edge where the count expires.

Behaviour:
- Reset values: out=0, busy=0, done=0, state=IDLE, prescaler=0.
- The FSM has two states: IDLE and RUN.
- `done` defaults to 0 every cycle; it is high only on the single cycle after an expiry edge.

IDLE:
- start=1 and load_val≠0: out←load_val, prescaler←0, state←RUN, busy←1, all on the same edge.
- start=1 and load_val=0: out←0, done←1, stay IDLE, busy stays 0.
- start=0: all outputs hold.

RUN:
- A tick occurs when the prescaler equals PRESCALE−1 and pause=0. On a tick the prescaler wraps to 0; otherwise it increments (only when pause=0).
- Tick with out>1: out←out−1.
- Tick with out=1 (expiry): out←0, done←1, busy←0, state←IDLE.
- pause=1: out and the prescaler freeze; no tick; busy stays 1.
- start=1 in RUN (restart): treated exactly like start in IDLE. It takes priority over a coincident tick or pause, and the prescaler clears.

Timing and limits:
- Latency with PRESCALE=1 and pause=0: start accepted at edge k gives out=N after edge k; out=0, done=1, busy=0 after edge k+N.
- General case: expiry after N·PRESCALE edges plus any paused cycles.
- No underflow: out never wraps below 0 and never exceeds load_val.
- rst mid-count: everything returns to reset values on that edge; a pending done is lost.
- `start` is level-sampled: holding it high keeps restarting the count.

Optional Feature:
Macro AUTO_RELOAD_EN.

Defined:
- On expiry, if the current load_val≠0: out←load_val, done←1, stay RUN, busy stays 1. The count therefore never shows 0, and the period is N·PRESCALE cycles.
- If load_val=0 at expiry: behaves as without the macro.

Undefined:
- Single-shot, as described in Behaviour.

Decomposition:
- Shared package `ripple_timer_pkg` holds:
  - state encoding localparams ST_IDLE=1'b0 and ST_RUN=1'b1;
  - default WIDTH and PRESCALE constants.
- One sub-module, `tick_gen`, holds the prescaler counter.
  - Parameter: PRESCALE.
  - Inputs: clk, rst, clr, hold.
  - Output: tick.
  - Width: $clog2(PRESCALE), minimum 1.

Test Plan:
1. Reset, then start with load_val=3, PRESCALE=1 → out 3,2,1,0 on successive edges; done=1 only in the out=0 cycle; busy falls together with done.
2. PRESCALE=4, load_val=2 → out holds 2 for 4 cycles, then 1 for 4 cycles, then 0 with done; 8 cycles total from the start edge.
3. load_val=3, pause high for 5 cycles after out=2 → out stays 2 for 5 extra cycles, then resumes 1,0; done occurs 5 cycles later than in scenario 1.
4. Start again (load_val=3) while out=1 → out←3 next edge with no done pulse, then full countdown; start at load_val=0 → done pulse and busy stays 0.
5. rst asserted while out=2 → next edge out=0, busy=0, done=0; no done afterwards without a new start.
6. AUTO_RELOAD_EN, load_val=2 → out 2,1,2,1,… with done every 2nd cycle; switch load_val to 0 → at next expiry out=0, busy=0.
